// File: rtl/kbd_host_buffer.sv
// Consumer end of the keyboard interrupt handshake: acknowledges bytes from the driver,
// queues them in a small FIFO, and exposes DATA/STATUS registers plus a level interrupt.
module kbd_host_buffer #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kbd_int_req,
    input  logic [7:0]  kbd_data,
    output logic        kbd_int_ack,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic        bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

    typedef enum logic [0:0] {
        H_IDLE = 1'b0,
        H_ACK  = 1'b1
    } hstate_e;

    hstate_e               r_hstate;
    logic                  r_ack;
    logic                  r_req_meta;
    logic                  r_req_s;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovf;
    logic [31:0]           r_rdata;
    logic                  r_irq;

    logic                  w_push_attempt;
    logic                  w_push_ok;
    logic                  w_push_drop;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_clr_ovf;
    logic                  w_full;
    logic                  w_nonempty;
    logic [3:0]            w_count4;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic [31:0]           w_status;
    logic                  w_unused_wdata;

    assign kbd_int_ack = r_ack;
    assign bus_rdata   = r_rdata;
    assign irq         = r_irq;

    assign w_unused_wdata = ^{bus_wdata[31:3], bus_wdata[1]};

    // Two-flop synchronizer for the asynchronous request line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_meta <= 1'b0;
            r_req_s    <= 1'b0;
        end else begin
            r_req_meta <= kbd_int_req;
            r_req_s    <= r_req_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hstate <= H_IDLE;
            r_ack    <= 1'b0;
        end else begin
            case (r_hstate)
                H_IDLE: begin
                    if (r_req_s) begin
                        r_ack    <= 1'b1;
                        r_hstate <= H_ACK;
                    end
                end
                H_ACK: begin
                    if (!r_req_s) begin
                        r_ack    <= 1'b0;
                        r_hstate <= H_IDLE;
                    end
                end
                default: begin
                    r_ack    <= 1'b0;
                    r_hstate <= H_IDLE;
                end
            endcase
        end
    end

    assign w_full         = (r_count == FULL_COUNT);
    assign w_nonempty     = (r_count != '0);
    assign w_count4       = 4'(r_count);
    assign w_push_attempt = (r_hstate == H_IDLE) && r_req_s;
    assign w_flush        = bus_wr && bus_addr && bus_wdata[0];
    assign w_clr_ovf      = bus_wr && bus_addr && bus_wdata[2];
    assign w_pop          = bus_rd && !bus_addr && w_nonempty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push_ok      = w_push_attempt && !w_flush && (!w_full || w_pop);
    assign w_push_drop    = w_push_attempt && !w_flush && w_full && !w_pop;
    assign w_status       = {20'b0, w_count4, 5'b0, r_ovf, w_full, w_nonempty};

    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else if (w_push_ok && !w_pop) begin
            w_count_next = r_count + CNT_ONE;
        end else if (w_pop && !w_push_ok) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= kbd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_irq   <= w_nonempty;
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wptr <= r_wptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_ONE;
                end
            end
            if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end
            if (w_push_drop) begin
                r_ovf <= 1'b1;
            end
            if (bus_rd) begin
                if (bus_addr) begin
                    r_rdata <= w_status;
                end else if (w_nonempty) begin
                    r_rdata <= {24'b0, r_mem[r_rptr]};
                end else begin
                    r_rdata <= '0;
                end
            end
        end
    end

endmodule
